// File: rtl/mcpu_mem_pkg.sv
// mcpu_mem_pkg: shared definitions for the memory-subsystem clients.
//   - LTC opcode encodings and a read-type classifier
//   - sweep controller state enum
//   - line-address width (address bits [31:5] of a 32-byte line)
//   - request record carried by the sweep controller
package mcpu_mem_pkg;

  localparam int LINE_AW   = 27;
  localparam int LTC_OPC_W = 3;

  localparam logic [LTC_OPC_W-1:0] LTC_OPC_NOP         = 3'd0;
  localparam logic [LTC_OPC_W-1:0] LTC_OPC_READ        = 3'd1;
  localparam logic [LTC_OPC_W-1:0] LTC_OPC_READTHROUGH = 3'd2;
  localparam logic [LTC_OPC_W-1:0] LTC_OPC_WRITE       = 3'd3;
  localparam logic [LTC_OPC_W-1:0] LTC_OPC_CLEAN       = 3'd4;
  localparam logic [LTC_OPC_W-1:0] LTC_OPC_INVAL       = 3'd5;
  localparam logic [LTC_OPC_W-1:0] LTC_OPC_FLUSH       = 3'd6;
  localparam logic [LTC_OPC_W-1:0] LTC_OPC_EVICT       = 3'd7;

  typedef enum logic [1:0] {
    SWEEP_IDLE  = 2'd0,
    SWEEP_ISSUE = 2'd1,
    SWEEP_DRAIN = 2'd2,
    SWEEP_DONE  = 2'd3
  } sweep_state_e;

  typedef struct packed {
    logic [LTC_OPC_W-1:0] opcode;
    logic [LINE_AW-1:0]   addr;
  } ltc_req_t;

  // Only read-type opcodes produce a return and therefore consume a credit.
  function automatic logic ltc_opc_is_read(input logic [LTC_OPC_W-1:0] opc);
    return (opc == LTC_OPC_READ) || (opc == LTC_OPC_READTHROUGH);
  endfunction

endpackage

// File: rtl/mcpu_mem_credit_ctr.sv
// mcpu_mem_credit_ctr: up/down counter of reads in flight for one arbiter client.
//   clk, rst   : clock, synchronous active-high reset (clears the count)
//   inc        : a read-type request was accepted this cycle
//   dec        : a read return arrived this cycle
//   chk_en     : returns are expected (owner is mid-operation); gates the underflow check
//   cnt        : current number of reads in flight
//   at_limit   : cnt has reached MAX_OUTSTANDING, no further reads may issue
//   empty      : nothing in flight
// A return with nothing in flight never wraps the counter; it holds at 0.
module mcpu_mem_credit_ctr #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUTS_BITS       = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 dec,
  input  logic                 chk_en,
  output logic [OUTS_BITS-1:0] cnt,
  output logic                 at_limit,
  output logic                 empty
);

  localparam logic [OUTS_BITS-1:0] LIMIT = OUTS_BITS'(MAX_OUTSTANDING);
  localparam logic [OUTS_BITS-1:0] ONE   = OUTS_BITS'(1);

  logic underflow;

  assign empty     = (cnt == '0);
  assign at_limit  = (cnt >= LIMIT);
  assign underflow = dec && !inc && empty;

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (rst)                       cnt <= '0;
    else if (inc && !dec)          cnt <= cnt + ONE;
    else if (dec && !inc && !empty) cnt <= cnt - ONE;
  end

  // Returns that straggle in after a reset arrive while the owner is idle,
  // so they are tolerated there; anywhere else a return at zero is a bug.
  always_ff @(posedge clk) begin
    if (!rst && chk_en) begin
      assert (!underflow)
        else $error("mcpu_mem_credit_ctr: read return with no read outstanding");
    end
  end

endmodule

// File: rtl/mcpu_mem_sweep.sv
// mcpu_mem_sweep: walks a contiguous range of 32-byte lines and issues one LTC
// request per line through an arbiter client port, bounding reads in flight.
//   clkrst_mem_clk / clkrst_mem_rst : clock, synchronous active-high reset
//   sweep_start/opcode/base/count    : command; sampled when accepted in IDLE
//   sweep_abort                      : stop issuing (only with MCPU_MEM_SWEEP_ABORT_EN)
//   sweep_busy/done/remaining        : status back to the CPU-side control
//   cli2arb_*                        : arbiter client request / read-return port
// Build option: define MCPU_MEM_SWEEP_ABORT_EN to add the sweep_abort port.
module mcpu_mem_sweep
  import mcpu_mem_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int OUTS_BITS       = 3,
  parameter int COUNT_BITS      = 16
) (
  input  logic                  clkrst_mem_clk,
  input  logic                  clkrst_mem_rst,
  input  logic                  sweep_start,
  input  logic [LTC_OPC_W-1:0]  sweep_opcode,
  input  logic [LINE_AW-1:0]    sweep_base,
  input  logic [COUNT_BITS-1:0] sweep_count,
`ifdef MCPU_MEM_SWEEP_ABORT_EN
  input  logic                  sweep_abort,
`endif
  output logic                  sweep_busy,
  output logic                  sweep_done,
  output logic [COUNT_BITS-1:0] sweep_remaining,
  output logic                  cli2arb_valid,
  output logic [LTC_OPC_W-1:0]  cli2arb_opcode,
  output logic [LINE_AW-1:0]    cli2arb_addr,
  output logic [255:0]          cli2arb_wdata,
  output logic [31:0]           cli2arb_wbe,
  input  logic                  cli2arb_stall,
  input  logic                  cli2arb_rvalid,
  input  logic [255:0]          cli2arb_rdata
);

  localparam logic [COUNT_BITS-1:0] CNT_ONE  = COUNT_BITS'(1);
  localparam logic [LINE_AW-1:0]    ADDR_ONE = LINE_AW'(1);

  sweep_state_e          state_q, state_d;
  ltc_req_t              req_q, req_d;
  logic [COUNT_BITS-1:0] rem_q, rem_d;
  logic                  abort_pend_q, abort_pend_d;

  logic [OUTS_BITS-1:0]  outs_cnt;
  logic                  outs_full, outs_empty;
  logic                  req_is_read, issue_valid, accept, abort_req, stop_now;
  logic                  unused_rdata;

`ifdef MCPU_MEM_SWEEP_ABORT_EN
  assign abort_req = sweep_abort;
`else
  assign abort_req = 1'b0;
`endif

  // Read data is not consumed here; only the return strobe matters.
  assign unused_rdata = ^{cli2arb_rdata, outs_cnt};

  assign req_is_read = ltc_opc_is_read(req_q.opcode);
  // Valid is purely a function of registered state. While stalled the credit
  // count can only fall, so a raised request never drops before acceptance.
  assign issue_valid = (state_q == SWEEP_ISSUE) && (!outs_full || !req_is_read);
  assign accept      = issue_valid && !cli2arb_stall;
  assign stop_now    = abort_pend_q || abort_req;

  mcpu_mem_credit_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .OUTS_BITS       (OUTS_BITS)
  ) u_credit (
    .clk      (clkrst_mem_clk),
    .rst      (clkrst_mem_rst),
    .inc      (accept && req_is_read),
    .dec      (cli2arb_rvalid),
    .chk_en   (state_q != SWEEP_IDLE),
    .cnt      (outs_cnt),
    .at_limit (outs_full),
    .empty    (outs_empty)
  );

  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    rem_d        = rem_q;
    abort_pend_d = 1'b0;
    unique case (state_q)
      SWEEP_IDLE: begin
        if (sweep_start) begin
          if (sweep_count != '0) begin
            req_d.opcode = sweep_opcode;
            req_d.addr   = sweep_base;
            rem_d        = sweep_count;
            state_d      = SWEEP_ISSUE;
          end else begin
            state_d = SWEEP_DONE;
          end
        end
      end
      SWEEP_ISSUE: begin
        if (accept) begin
          req_d.addr = req_q.addr + ADDR_ONE;  // wraps at 2^27
          rem_d      = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE || stop_now) state_d = SWEEP_DRAIN;
        end else if (stop_now && !issue_valid) begin
          state_d = SWEEP_DRAIN;
        end else begin
          // An abort against a stalled request waits for that request to go.
          abort_pend_d = stop_now;
        end
      end
      SWEEP_DRAIN: begin
        if (outs_empty) state_d = SWEEP_DONE;
      end
      SWEEP_DONE: begin
        state_d = SWEEP_IDLE;
      end
      default: state_d = SWEEP_IDLE;
    endcase
  end

  always_ff @(posedge clkrst_mem_clk) begin
    if (clkrst_mem_rst) begin
      state_q      <= SWEEP_IDLE;
      req_q        <= '0;
      rem_q        <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      rem_q        <= rem_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign sweep_busy      = (state_q != SWEEP_IDLE);
  assign sweep_done      = (state_q == SWEEP_DONE);
  assign sweep_remaining = rem_q;
  assign cli2arb_valid   = issue_valid;
  assign cli2arb_opcode  = req_q.opcode;
  assign cli2arb_addr    = req_q.addr;
  assign cli2arb_wdata   = '0;
  assign cli2arb_wbe     = '0;

endmodule

// File: tb/tb_mcpu_mem_sweep.sv
module tb_mcpu_mem_sweep;
  import mcpu_mem_pkg::*;

  localparam int MAXO = 4;
  localparam int CB   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0, stall = 1'b0, rvalid = 1'b0;
  logic [2:0]    opc_in = '0;
  logic [26:0]   base_in = '0;
  logic [CB-1:0] cnt_in = '0;
  logic [255:0]  rdata = '0;
`ifdef MCPU_MEM_SWEEP_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic          busy, done, valid;
  logic [CB-1:0] remaining;
  logic [2:0]    opc_out;
  logic [26:0]   addr_out;
  logic [255:0]  wdata;
  logic [31:0]   wbe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mcpu_mem_sweep #(.MAX_OUTSTANDING(MAXO), .OUTS_BITS(3), .COUNT_BITS(CB)) dut (
    .clkrst_mem_clk  (clk),
    .clkrst_mem_rst  (rst),
    .sweep_start     (start),
    .sweep_opcode    (opc_in),
    .sweep_base      (base_in),
    .sweep_count     (cnt_in),
`ifdef MCPU_MEM_SWEEP_ABORT_EN
    .sweep_abort     (abort),
`endif
    .sweep_busy      (busy),
    .sweep_done      (done),
    .sweep_remaining (remaining),
    .cli2arb_valid   (valid),
    .cli2arb_opcode  (opc_out),
    .cli2arb_addr    (addr_out),
    .cli2arb_wdata   (wdata),
    .cli2arb_wbe     (wbe),
    .cli2arb_stall   (stall),
    .cli2arb_rvalid  (rvalid),
    .cli2arb_rdata   (rdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [26:0] b, input int n, input logic [2:0] op);
    base_in = b; cnt_in = CB'(n); opc_in = op; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  // Rule-based model: lines must appear in order base+i (mod 2^27), reads in
  // flight never exceed MAXO, valid is high whenever a line is pending and a
  // credit is free, and done comes one cycle after everything is issued and returned.
  task automatic run_sweep(input logic [26:0] b, input int n, input logic [2:0] op,
                           input int st_pct, input int rv_pct,
                           output logic [26:0] last_a, output int rets);
    int  acc, outs, zero_at;
    bit  is_rd, seen;
    is_rd = (op == LTC_OPC_READ) || (op == LTC_OPC_READTHROUGH);
    acc = 0; outs = 0; rets = 0; seen = 0; zero_at = -1; last_a = '0;
    go(b, n, op);
    chk("start_busy", {63'b0, busy}, 64'd1);
    for (int c = 0; c < 3000 && !seen; c++) begin
      if (acc == n && outs == 0 && zero_at < 0) zero_at = c;
      if (done) begin
        seen = 1;
        chk("done_latency", c, zero_at + 1);
        chk("done_lines", acc, n);
      end else begin
        chk("remaining", remaining, CB'(n - acc));
        if (acc < n && (!is_rd || outs < MAXO)) chk("valid_on", {63'b0, valid}, 64'd1);
        else                                     chk("valid_off", {63'b0, valid}, 64'd0);
        if (valid) begin
          chk("addr_seq", addr_out, 27'(b + 27'(acc)));
          chk("opcode", opc_out, op);
        end
        stall  = ($urandom_range(99) < st_pct);
        rvalid = (outs > 0) && ($urandom_range(99) < rv_pct);
        if (valid && !stall) begin
          last_a = addr_out; acc++;
          if (is_rd) outs++;
        end
        if (rvalid) begin outs--; rets++; end
        cyc();
      end
    end
    stall = 1'b0; rvalid = 1'b0;
    chk("done_seen", {63'b0, seen}, 64'd1);
    cyc();
    chk("done_pulse", {63'b0, done}, 64'd0);
    chk("idle_busy", {63'b0, busy}, 64'd0);
  endtask

  typedef struct {
    logic [26:0] base;
    int          n;
    logic [2:0]  op;
    int          st;
    int          rv;
    logic [26:0] exp_last;
    int          exp_rets;
  } vec_t;

  vec_t        tbl[5];
  logic [26:0] la;
  int          rr, acc;

  initial begin
    tbl[0] = '{27'h0000100, 3,  LTC_OPC_READ,        0,  100, 27'h0000102, 3};
    tbl[1] = '{27'h7FFFFFE, 3,  LTC_OPC_CLEAN,       0,  0,   27'h0000000, 0};
    tbl[2] = '{27'h00ABCDE, 12, LTC_OPC_READTHROUGH, 30, 40,  27'h00ABCE9, 12};
    tbl[3] = '{27'h7FFFFF0, 20, LTC_OPC_READ,        20, 20,  27'h0000003, 20};
    tbl[4] = '{27'h0001234, 5,  LTC_OPC_FLUSH,       50, 0,   27'h0001238, 0};

    // Reset values
    cyc(); cyc();
    chk("rst_valid", {63'b0, valid}, 64'd0);
    chk("rst_busy",  {63'b0, busy},  64'd0);
    chk("rst_done",  {63'b0, done},  64'd0);
    chk("rst_rem",   remaining, 64'd0);
    chk("rst_addr",  addr_out, 64'd0);
    chk("rst_opc",   opc_out, 64'd0);
    chk("rst_wdata", {63'b0, |wdata}, 64'd0);
    chk("rst_wbe",   wbe, 64'd0);
    rst = 1'b0;
    cyc();

    // Table-driven sweeps
    for (int i = 0; i < 5; i++) begin
      run_sweep(tbl[i].base, tbl[i].n, tbl[i].op, tbl[i].st, tbl[i].rv, la, rr);
      chk("tbl_last_addr", la, tbl[i].exp_last);
      chk("tbl_returns", rr, tbl[i].exp_rets);
    end

    // Credit limit: returns withheld
    go(27'h300, 8, LTC_OPC_READ);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid) acc++;
      cyc();
    end
    chk("credit_accepts", acc, 4);
    chk("credit_blocked", {63'b0, valid}, 64'd0);
    chk("credit_rem", remaining, 64'd4);
    for (int k = 0; k < 4; k++) begin
      rvalid = 1'b1; cyc(); rvalid = 1'b0;
      chk("credit_recover", {63'b0, valid}, 64'd1);
      chk("credit_addr", addr_out, 27'h304 + 27'(k));
      cyc();
      chk("credit_reblock", {63'b0, valid}, 64'd0);
    end
    for (int k = 0; k < 4; k++) begin
      chk("drain_no_done", {63'b0, done}, 64'd0);
      rvalid = 1'b1; cyc(); rvalid = 1'b0;
    end
    chk("drain_zero_seen", {63'b0, done}, 64'd0);
    cyc();
    chk("drain_done", {63'b0, done}, 64'd1);
    cyc();
    chk("drain_idle", {63'b0, busy}, 64'd0);

    // Stall hold, plus start while busy
    go(27'h200, 4, LTC_OPC_CLEAN);
    chk("stall_a0", addr_out, 64'h200);
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("stall_addr", addr_out, 64'h201);
      chk("stall_opc", opc_out, LTC_OPC_CLEAN);
      chk("stall_rem", remaining, 64'd3);
      chk("stall_valid", {63'b0, valid}, 64'd1);
      if (i == 1) begin
        base_in = 27'h555; cnt_in = 2; opc_in = LTC_OPC_READ; start = 1'b1;
      end
      cyc();
      start = 1'b0;
    end
    chk("stall_addr_end", addr_out, 64'h201);
    stall = 1'b0;
    cyc();
    chk("stall_a2", addr_out, 64'h202);
    cyc();
    chk("stall_a3", addr_out, 64'h203);
    cyc();
    chk("stall_drain_valid", {63'b0, valid}, 64'd0);
    chk("stall_drain_rem", remaining, 64'd0);
    cyc();
    chk("stall_done", {63'b0, done}, 64'd1);
    cyc();
    chk("stall_idle", {63'b0, busy}, 64'd0);
    chk("busy_start_ignored", {63'b0, valid}, 64'd0);

    // Zero-length sweep
    go(27'h10, 0, LTC_OPC_READ);
    chk("zero_done", {63'b0, done}, 64'd1);
    chk("zero_busy", {63'b0, busy}, 64'd1);
    chk("zero_valid", {63'b0, valid}, 64'd0);
    cyc();
    chk("zero_done_end", {63'b0, done}, 64'd0);
    chk("zero_busy_end", {63'b0, busy}, 64'd0);

    // Reset mid-sweep with two reads outstanding, then late returns
    go(27'h400, 6, LTC_OPC_READ);
    cyc(); cyc();
    stall = 1'b1; rst = 1'b1;
    cyc();
    stall = 1'b0; rst = 1'b0;
    chk("mrst_valid", {63'b0, valid}, 64'd0);
    chk("mrst_busy", {63'b0, busy}, 64'd0);
    chk("mrst_rem", remaining, 64'd0);
    rvalid = 1'b1; cyc(); cyc(); rvalid = 1'b0;
    acc = 0;
    for (int i = 0; i < 4; i++) begin
      if (done || busy) acc++;
      cyc();
    end
    chk("mrst_quiet", acc, 0);
    go(27'h480, 6, LTC_OPC_READ);
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (valid) acc++;
      cyc();
    end
    chk("mrst_credit_clean", acc, 4);
    rst = 1'b1; cyc(); rst = 1'b0; cyc();

`ifdef MCPU_MEM_SWEEP_ABORT_EN
    // Abort against a stalled fourth request
    go(27'h500, 10, LTC_OPC_READ);
    cyc(); cyc(); cyc();
    chk("abort_valid4", {63'b0, valid}, 64'd1);
    stall = 1'b1; abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("abort_held_addr", addr_out, 64'h503);
    chk("abort_held_valid", {63'b0, valid}, 64'd1);
    cyc();
    stall = 1'b0;
    cyc();
    chk("abort_stop", {63'b0, valid}, 64'd0);
    chk("abort_rem", remaining, 64'd6);
    for (int k = 0; k < 4; k++) begin
      chk("abort_no_done", {63'b0, done}, 64'd0);
      rvalid = 1'b1; cyc(); rvalid = 1'b0;
    end
    chk("abort_zero_seen", {63'b0, done}, 64'd0);
    cyc();
    chk("abort_done", {63'b0, done}, 64'd1);
    chk("abort_done_rem", remaining, 64'd6);
    cyc();
`endif

    // Randomized sweeps
    for (int i = 0; i < 10; i++) begin
      logic [26:0] b;
      int n, st, rv;
      logic [2:0] op;
      b  = 27'($urandom);
      n  = $urandom_range(16, 1);
      op = 3'($urandom_range(7));
      st = $urandom_range(60);
      rv = $urandom_range(80, 10);
      run_sweep(b, n, op, st, rv, la, rr);
      chk("rnd_last_addr", la, 27'(b + 27'(n - 1)));
      chk("rnd_returns", rr, ((op == LTC_OPC_READ) || (op == LTC_OPC_READTHROUGH)) ? n : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
